// File: rtl/alarm_sequencer.sv
// Alarm sequencer for the digital alarm clock.
// It detects the rising edge of the time==alarm match, runs the ring / snooze / stop
// sequence, and drives the buzzer. All outputs are registered.
module alarm_sequencer #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [4:0] alm_hours,
    input  logic [5:0] alm_minutes,
    input  logic       alarm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic [1:0] state,
    output logic       ringing,
    output logic       buzzer,
    output logic [3:0] snooze_cnt,
    output logic       missed
);

    // state      | meaning
    // S_DISABLED | alarm function off, everything cleared
    // S_ARMED    | waiting for the rising edge of the time match
    // S_RINGING  | buzzer beeping at 1 Hz, ring timer running
    // S_SNOOZED  | silent, snooze timer running, returns to ringing on expiry
    localparam logic [1:0] S_DISABLED = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_RINGING  = 2'd2;
    localparam logic [1:0] S_SNOOZED  = 2'd3;

    localparam int SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int TIMER_MAX  = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int TW         = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] RING_LAST   = TW'(RING_SEC - 1);
    localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SEC - 1);
    localparam logic [3:0]    SNOOZE_LIM  = 4'(MAX_SNOOZE);

    logic          match;
    logic          match_q;
    logic          trigger;
    logic [TW-1:0] timer;

    logic [1:0]    state_nx;
    logic [TW-1:0] timer_nx;
    logic          buzzer_nx;
    logic [3:0]    snooze_cnt_nx;
    logic          missed_nx;

    assign match   = (cur_hours == alm_hours) && (cur_minutes == alm_minutes);
    // Only the first cycle of a match triggers; a match that persists after stop,
    // or that was already present when enabling, is therefore ignored.
    assign trigger = match & ~match_q;

    // Delayed match, updated every cycle regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    // Next-state and datapath decode; alarm_en=0 overrides everything at the end.
    always_comb begin
        state_nx      = state;
        timer_nx      = timer;
        buzzer_nx     = buzzer;
        snooze_cnt_nx = snooze_cnt;
        missed_nx     = 1'b0;

        case (state)
            S_DISABLED: begin
                timer_nx  = '0;
                buzzer_nx = 1'b0;
                if (alarm_en) begin
                    state_nx = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trigger) begin
                    state_nx      = S_RINGING;
                    timer_nx      = '0;
                    buzzer_nx     = 1'b1;
                    snooze_cnt_nx = 4'd0;
                end
            end
            S_RINGING: begin
                if (stop_btn) begin
                    state_nx  = S_ARMED;
                    timer_nx  = '0;
                    buzzer_nx = 1'b0;
                end else if (snooze_btn && (snooze_cnt < SNOOZE_LIM)) begin
                    state_nx      = S_SNOOZED;
                    timer_nx      = '0;
                    buzzer_nx     = 1'b0;
                    snooze_cnt_nx = snooze_cnt + 4'd1;
                end else if (sec_tick) begin
                    if (timer == RING_LAST) begin
                        state_nx  = S_ARMED;
                        timer_nx  = '0;
                        buzzer_nx = 1'b0;
                        missed_nx = 1'b1;
                    end else begin
                        timer_nx  = timer + 1'b1;
                        buzzer_nx = ~buzzer;
                    end
                end
            end
            S_SNOOZED: begin
                if (stop_btn) begin
                    state_nx  = S_ARMED;
                    timer_nx  = '0;
                    buzzer_nx = 1'b0;
                end else if (sec_tick) begin
                    if (timer == SNOOZE_LAST) begin
                        state_nx  = S_RINGING;
                        timer_nx  = '0;
                        buzzer_nx = 1'b1;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_DISABLED;
            end
        endcase

        if (!alarm_en) begin
            state_nx      = S_DISABLED;
            timer_nx      = '0;
            buzzer_nx     = 1'b0;
            snooze_cnt_nx = 4'd0;
            missed_nx     = 1'b0;
        end
    end

    // Registered state and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_DISABLED;
            timer      <= '0;
            buzzer     <= 1'b0;
            ringing    <= 1'b0;
            snooze_cnt <= 4'd0;
            missed     <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            buzzer     <= buzzer_nx;
            ringing    <= (state_nx == S_RINGING);
            snooze_cnt <= snooze_cnt_nx;
            missed     <= missed_nx;
        end
    end

endmodule
